// File: rtl/approx_adder_pipe_mon_pkg.sv
// Shared helpers for the LOA approximate adder pipeline: sum/diff/saturation functions
// operate on a fixed wide type so any WIDTH up to MAX_W can reuse them.
package approx_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_ET    = 2;
   localparam int MAX_W     = 64;

   typedef logic [MAX_W-1:0] opnd_t;
   typedef logic [MAX_W:0]   wsum_t;
   typedef logic [63:0]      cnt_t;

   // Lower K bits are OR'd; carry into the exact upper part is the AND of bit K-1.
   function automatic wsum_t loa_sum(input opnd_t a, input opnd_t b, input int k);
      wsum_t low;
      wsum_t ah;
      wsum_t bh;
      logic  cin;
      low = '0;
      cin = 1'b0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < k) low[i] = a[i] | b[i];
         if (i == k - 1) cin = a[i] & b[i];
      end
      ah = {1'b0, a} >> k;
      bh = {1'b0, b} >> k;
      return low | ((ah + bh + wsum_t'(cin)) << k);
   endfunction

   function automatic wsum_t abs_diff(input wsum_t x, input wsum_t y);
      return (x > y) ? (x - y) : (y - x);
   endfunction

   function automatic cnt_t sat_inc(input cnt_t v, input int w);
      cnt_t top;
      top = (w >= 64) ? '1 : ((cnt_t'(1) << w) - cnt_t'(1));
      return (v >= top) ? top : (v + cnt_t'(1));
   endfunction

endpackage

// File: rtl/approx_adder_pipe_mon_loa_adder.sv
// Combinational lower-part-OR adder: APPROX_BITS LSBs OR'd, the rest added exactly.
import approx_pkg::*;

module loa_adder #(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int APPROX_BITS = 3
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   sum
);

   wsum_t sum_wide;
   logic  unused_hi;

   assign sum_wide  = loa_sum(opnd_t'(a), opnd_t'(b), APPROX_BITS);
   assign sum       = sum_wide[WIDTH:0];
   assign unused_hi = ^sum_wide;

endmodule

// File: rtl/approx_adder_pipe_mon.sv
// Two-stage valid/ready LOA adder with optional runtime error monitor.
// Define ERR_MONITOR_EN to build the exact reference path, per-result error and stats.
import approx_pkg::*;

module approx_adder_pipe_mon #(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int APPROX_BITS = 3,
   parameter int ET          = DEF_ET,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_sum,
   output logic [WIDTH:0]   out_err,
   output logic             out_viol,
   input  logic             clr_stats,
   output logic [CNT_W-1:0] viol_cnt,
   output logic [WIDTH:0]   max_err
);

   logic             s1_v;
   logic [WIDTH-1:0] s1_a, s1_b;
   logic             s1_adv, s2_adv, fire;
   logic [WIDTH:0]   approx_sum;

   // S2 can take new data when empty or its result leaves this cycle.
   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_v || s2_adv;
   assign in_ready = s1_adv;
   assign fire     = out_valid && out_ready;

   loa_adder #(.WIDTH(WIDTH), .APPROX_BITS(APPROX_BITS)) u_loa (
      .a   (s1_a),
      .b   (s1_b),
      .sum (approx_sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v <= 1'b0;
         s1_a <= '0;
         s1_b <= '0;
      end else if (s1_adv) begin
         s1_v <= in_valid;
         if (in_valid) begin
            s1_a <= in_a;
            s1_b <= in_b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_v;
         if (s1_v) out_sum <= approx_sum;
      end
   end

`ifdef ERR_MONITOR_EN
   logic [WIDTH:0] exact_sum, cur_err;
   wsum_t          err_wide;
   cnt_t           cnt_next;
   logic           unused_wide;

   assign exact_sum   = {1'b0, s1_a} + {1'b0, s1_b};
   assign err_wide    = abs_diff(wsum_t'(exact_sum), wsum_t'(approx_sum));
   assign cur_err     = err_wide[WIDTH:0];
   assign cnt_next    = sat_inc(cnt_t'(viol_cnt), CNT_W);
   assign unused_wide = ^{err_wide, cnt_next};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_err  <= '0;
         out_viol <= 1'b0;
      end else if (s2_adv && s1_v) begin
         out_err  <= cur_err;
         out_viol <= cur_err > (WIDTH+1)'(ET);
      end
   end

   // Clear takes priority over a result leaving in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         viol_cnt <= '0;
         max_err  <= '0;
      end else if (clr_stats) begin
         viol_cnt <= '0;
         max_err  <= '0;
      end else if (fire) begin
         if (out_viol) viol_cnt <= cnt_next[CNT_W-1:0];
         if (out_err > max_err) max_err <= out_err;
      end
   end
`else
   localparam int unused_et = ET;
   logic unused_cfg;

   assign out_err    = '0;
   assign out_viol   = 1'b0;
   assign viol_cnt   = '0;
   assign max_err    = '0;
   assign unused_cfg = clr_stats ^ fire;
`endif

endmodule

// File: tb/tb_approx_adder_pipe_mon.sv
// Randomized + directed bench for approx_adder_pipe_mon against a queue-based model.
module tb_approx_adder_pipe_mon;

`ifdef ERR_MONITOR_EN
   localparam bit MON = 1'b1;
`else
   localparam bit MON = 1'b0;
`endif
   localparam int ET = 2;
   localparam int CMAX = 3;  // saturation value for CNT_W=2

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_a = '0, in_b = '0;
   logic       out_ready = 1'b1;
   logic       clr_stats = 1'b0;

   logic       in_ready, out_valid, out_viol;
   logic [8:0] out_sum, out_err, max_err;
   logic [1:0] viol_cnt;
   logic        in_ready_z, out_valid_z, out_viol_z;
   logic [8:0]  out_sum_z, out_err_z, max_err_z;
   logic [15:0] viol_cnt_z;

   approx_adder_pipe_mon #(.WIDTH(8), .APPROX_BITS(3), .ET(ET), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_err(out_err), .out_viol(out_viol),
      .clr_stats(clr_stats), .viol_cnt(viol_cnt), .max_err(max_err));

   approx_adder_pipe_mon #(.WIDTH(8), .APPROX_BITS(0), .ET(ET), .CNT_W(16)) dut_z (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_z),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid_z), .out_ready(out_ready),
      .out_sum(out_sum_z), .out_err(out_err_z), .out_viol(out_viol_z),
      .clr_stats(clr_stats), .viol_cnt(viol_cnt_z), .max_err(max_err_z));

   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: low 3 bits OR'd, carry = a[2]&b[2], upper bits added exactly.
   function automatic int ref_sum(input int a, input int b);
      int low, cin, high;
      low  = (a | b) & 7;
      cin  = (a >> 2) & (b >> 2) & 1;
      high = (a >> 3) + (b >> 3) + cin;
      return (high << 3) | low;
   endfunction

   function automatic int ref_err(input int a, input int b);
      int d;
      d = (a + b) - ref_sum(a, b);
      if (d < 0) d = -d;
      return MON ? d : 0;
   endfunction

   int q_a[$], q_b[$], q_t[$];
   int cyc = 0, m_cnt = 0, m_max = 0;
   int hd_a, hd_b, e;
   bit exp_vld, exp_rdy;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 1);
         chk("rst_out_sum", out_sum, 0);
         chk("rst_out_err", out_err, 0);
         chk("rst_viol_cnt", viol_cnt, 0);
         chk("rst_max_err", max_err, 0);
         chk("rst_out_valid_z", out_valid_z, 0);
         q_a.delete(); q_b.delete(); q_t.delete();
         m_cnt = 0; m_max = 0;
      end else begin
         exp_vld = (q_t.size() > 0) && (cyc - q_t[0] >= 2);
         exp_rdy = (q_t.size() < 2) || out_ready;
         chk("out_valid", out_valid, exp_vld);
         chk("in_ready", in_ready, exp_rdy);
         chk("out_valid_z", out_valid_z, exp_vld);
         chk("in_ready_z", in_ready_z, exp_rdy);
         if (exp_vld) begin
            hd_a = q_a[0]; hd_b = q_b[0];
            e = ref_err(hd_a, hd_b);
            chk("out_sum", out_sum, ref_sum(hd_a, hd_b));
            chk("out_err", out_err, e);
            chk("out_viol", out_viol, e > ET);
            chk("out_sum_z", out_sum_z, hd_a + hd_b);
            chk("out_err_z", out_err_z, 0);
         end
         chk("viol_cnt", viol_cnt, m_cnt);
         chk("max_err", max_err, m_max);
         chk("viol_cnt_z", viol_cnt_z, 0);
         chk("max_err_z", max_err_z, 0);
         if (clr_stats && MON) begin
            m_cnt = 0; m_max = 0;
         end else if (exp_vld && out_ready) begin
            if (e > ET && m_cnt < CMAX) m_cnt++;
            if (e > m_max) m_max = e;
         end
         if (exp_vld && out_ready) begin
            void'(q_a.pop_front()); void'(q_b.pop_front()); void'(q_t.pop_front());
         end
         if (in_valid && in_ready) begin
            q_a.push_back(int'(in_a)); q_b.push_back(int'(in_b)); q_t.push_back(cyc);
         end
      end
   end

   // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
   task automatic push(input int a, input int b);
      int guard;
      guard = 0;
      in_valid = 1'b1; in_a = 8'(a); in_b = 8'(b);
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) chk("push_timeout", 1, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      idle(3);
      rst_n = 1'b1;
      idle(1);

      // 7+7: two-cycle latency, sum 0x00F, err 1
      push(7, 7);
      @(negedge clk); chk("lat_not_yet", out_valid, 0);
      @(negedge clk); chk("lat_valid", out_valid, 1);
      chk("t1_sum", out_sum, 9'h00F);
      chk("t1_err", out_err, MON ? 1 : 0);
      chk("t1_viol", out_viol, 0);
      idle(2);

      push(3, 3);
      @(negedge clk); @(negedge clk); chk("t2_sum_a", out_sum, 9'h003);
      idle(1);
      push(4, 4);
      @(negedge clk); @(negedge clk); chk("t2_sum_b", out_sum, 9'h00C);
      chk("t2_err_b", out_err, MON ? 4 : 0);
      idle(2);
      chk("t2_viol_cnt", viol_cnt, MON ? 2 : 0);
      chk("t2_max_err", max_err, MON ? 4 : 0);

      // clear coincident with a violating fire
      push(4, 4);
      idle(1);
      chk("t4_fire_pending", out_valid, 1);
      clr_stats = 1'b1;
      idle(1);
      clr_stats = 1'b0;
      @(negedge clk);
      chk("t4_viol_cnt", viol_cnt, 0);
      chk("t4_max_err", max_err, 0);
      idle(1);

      // burst of 8 with a 5-cycle stall
      fork
         begin
            out_ready = 1'b0;
            idle(5);
            out_ready = 1'b1;
         end
         begin
            for (int i = 0; i < 8; i++) push($urandom_range(0, 255), $urandom_range(0, 255));
         end
      join
      idle(4);
      chk("t3_drained", q_t.size(), 0);

      // saturation with CNT_W=2
      for (int i = 0; i < 5; i++) push(4, 4);
      idle(4);
      chk("t5_sat", viol_cnt, MON ? 3 : 0);
      chk("t5_max", max_err, MON ? 4 : 0);

      // reset mid-stream with both stages full
      out_ready = 1'b0;
      push(1, 2);
      push(5, 6);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_rst_valid", out_valid, 0);
      chk("t5_rst_cnt", viol_cnt, 0);
      chk("t5_rst_max", max_err, 0);
      idle(1);
      rst_n = 1'b1;
      out_ready = 1'b1;
      idle(1);

      // random traffic
      for (int i = 0; i < 1000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_a      = 8'($urandom_range(0, 255));
         in_b      = 8'($urandom_range(0, 255));
         out_ready = ($urandom_range(0, 3) != 0);
         clr_stats = ($urandom_range(0, 49) == 0);
         idle(1);
      end
      in_valid = 1'b0; clr_stats = 1'b0; out_ready = 1'b1;
      idle(5);
      chk("rand_drained", q_t.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
